// File: rtl/pitch_frame_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pitch_seq_pkg                                                            |
// | State encoding, default sizing and width helper for the frame sequencer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pitch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    TAIL      = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_t;

  localparam int FRAME_LEN_DEF = 500;
  localparam int GAP_CYC_DEF   = 2;
  localparam int TIMEOUT_DEF   = 4096;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int seq_cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pitch_frame_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pitch_frame_sequencer_if                                                 |
// | Raw sample input and vsync/href framed output of the frame sequencer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pitch_frame_sequencer_if #(
  parameter int DW = 16
) ();

  logic          in_de;
  logic [DW-1:0] in_data;
  logic          frm_vsync;
  logic          frm_href;
  logic [DW-1:0] frm_data;

  modport master (
    input  in_de,
    input  in_data,
    output frm_vsync,
    output frm_href,
    output frm_data
  );

  modport slave (
    output in_de,
    output in_data,
    input  frm_vsync,
    input  frm_href,
    input  frm_data
  );

endinterface
`default_nettype wire

// File: rtl/pitch_frame_sequencer_sat_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_sat_cnt                                                              |
// | Event counter with clear; SAT=1 saturates at all-ones, SAT=0 wraps.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_sat_cnt #(
  parameter int W   = 16,
  parameter bit SAT = 1'b0
) (
  input  wire logic         clk_in1,
  input  wire logic         rst_n,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic      [W-1:0] cnt
);

  localparam logic [W-1:0] c_ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic         w_hold;

  generate
    if (SAT) begin : g_sat
      assign w_hold = &r_cnt;
    end else begin : g_wrap
      assign w_hold = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_in1) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (inc && !w_hold) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pitch_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pitch_frame_sequencer                                                    |
// | Cuts the sample stream into vsync/href frames and holds off until the    |
// | downstream pipeline signals completion. SEQ_TIMEOUT_EN adds a wait limit.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pitch_frame_sequencer
  import pitch_seq_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int DW        = 16,
  parameter int CW        = 16
) (
  input  wire logic                 clk_in1,
  input  wire logic                 rst_n,
  input  wire logic                 en,
  input  wire logic                 proc_done,
  pitch_frame_sequencer_if.master   bus,
  output logic                      busy,
  output logic             [CW-1:0] frame_cnt,
  output logic             [CW-1:0] drop_cnt,
  output logic                      timeout_err
);

  localparam int c_CNT_W = seq_cnt_width(FRAME_LEN);
  localparam int c_GAP_W = seq_cnt_width(GAP_CYC);
  localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(FRAME_LEN);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

  generate
    if (FRAME_LEN < 2) begin : g_chk_frame_len
      $error("FRAME_LEN must be at least 2");
    end
    if (GAP_CYC < 1) begin : g_chk_gap_cyc
      $error("GAP_CYC must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
      $error("TIMEOUT must be at least 1");
    end
  endgenerate

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic [c_GAP_W-1:0] r_gap;
  logic [c_GAP_W-1:0] w_gap_nxt;
  logic               r_vsync;
  logic               w_vsync_nxt;
  logic               r_href;
  logic               w_href_nxt;
  logic [DW-1:0]      r_data;
  logic [DW-1:0]      w_data_nxt;
  logic               r_busy;
  logic               w_drop_inc;
  logic               w_frame_inc;

  assign w_cnt_inc = r_cnt + c_CNT_ONE;

`ifdef SEQ_TIMEOUT_EN
  localparam int c_WAIT_W = seq_cnt_width(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT  = c_WAIT_W'(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

  logic [c_WAIT_W-1:0] r_wait;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic [c_WAIT_W-1:0] w_wait_inc;
  logic                r_tout;
  logic                w_tout_set;

  assign w_wait_inc = r_wait + c_WAIT_ONE;
`endif

  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (en && bus.in_de) w_state_nxt = STREAM;
      end
      STREAM: begin
        if (bus.in_de && (w_cnt_inc == c_LAST)) w_state_nxt = TAIL;
      end
      TAIL: begin
        if (r_gap == c_GAP_LAST) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (proc_done) begin
          w_state_nxt = IDLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (w_wait_inc == c_TIMEOUT) begin
          w_state_nxt = IDLE;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output; href defaults low so data simply holds.
  always_comb begin
    w_vsync_nxt = r_vsync;
    w_href_nxt  = 1'b0;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_drop_inc  = 1'b0;
    w_frame_inc = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    w_wait_nxt  = r_wait;
    w_tout_set  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (en && bus.in_de) begin
          w_vsync_nxt = 1'b1;
          w_href_nxt  = 1'b1;
          w_data_nxt  = bus.in_data;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      STREAM: begin
        if (bus.in_de) begin
          w_href_nxt = 1'b1;
          w_data_nxt = bus.in_data;
          w_cnt_nxt  = w_cnt_inc;
          if (w_cnt_inc == c_LAST) w_gap_nxt = '0;
        end
      end
      TAIL: begin
        w_drop_inc = bus.in_de;
        if (r_gap == c_GAP_LAST) begin
          w_vsync_nxt = 1'b0;
`ifdef SEQ_TIMEOUT_EN
          w_wait_nxt  = '0;
`endif
        end else begin
          w_gap_nxt = r_gap + c_GAP_ONE;
        end
      end
      WAIT_DONE: begin
        w_drop_inc = bus.in_de;
        if (proc_done) begin
          w_frame_inc = 1'b1;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (w_wait_inc == c_TIMEOUT) begin
          w_tout_set = 1'b1;
        end else begin
          w_wait_nxt = w_wait_inc;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_vsync <= w_vsync_nxt;
      r_href  <= w_href_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_tout <= 1'b0;
    end else begin
      r_wait <= w_wait_nxt;
      r_tout <= r_tout | w_tout_set;
    end
  end

  assign timeout_err = r_tout;
`else
  assign timeout_err = 1'b0;
`endif

  seq_sat_cnt #(
    .W   (CW),
    .SAT (1'b1)
  ) u_drop_cnt (
    .clk_in1 (clk_in1),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .inc     (w_drop_inc),
    .cnt     (drop_cnt)
  );

  seq_sat_cnt #(
    .W   (CW),
    .SAT (1'b0)
  ) u_frame_cnt (
    .clk_in1 (clk_in1),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .inc     (w_frame_inc),
    .cnt     (frame_cnt)
  );

  assign bus.frm_vsync = r_vsync;
  assign bus.frm_href  = r_href;
  assign bus.frm_data  = r_data;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pitch_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pitch_frame_sequencer                                                 |
// | Randomised scenarios checked against a queue/counter model of framing.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pitch_frame_sequencer;

  localparam int FRAME_LEN = 8;
  localparam int GAP_CYC   = 2;
  localparam int TIMEOUT   = 64;
  localparam int DW        = 16;
  localparam int CW        = 16;

  logic          clk_in1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          proc_done = 1'b0;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frame = 0;
  int exp_drop  = 0;

  pitch_frame_sequencer_if #(.DW(DW)) bus ();

  pitch_frame_sequencer #(
    .FRAME_LEN (FRAME_LEN),
    .GAP_CYC   (GAP_CYC),
    .TIMEOUT   (TIMEOUT),
    .DW        (DW),
    .CW        (CW)
  ) dut (
    .clk_in1     (clk_in1),
    .rst_n       (rst_n),
    .en          (en),
    .proc_done   (proc_done),
    .bus         (bus.master),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt),
    .timeout_err (timeout_err)
  );

  always #10 clk_in1 = ~clk_in1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  // Feeds one frame (mode 0 back-to-back, 1 alternate cycles, 2 random gaps) and checks it.
  task automatic run_frame(input int mode, input bit fixed_data, input bit spurious, input bit en_drop);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int first_de = -1, first_href = -1, last_href = -1, fall = -1;
    int cyc = 0, sent = 0, bad_idx = -1;
    bit de, vs_err = 0, hold_err = 0;
    for (int i = 0; i < FRAME_LEN; i++)
      exp_q.push_back(fixed_data ? DW'(i + 1) : DW'($urandom));
    en = 1'b1;
    while (fall < 0 && cyc < 200) begin
      case (mode)
        0:       de = (sent < FRAME_LEN);
        1:       de = (sent < FRAME_LEN) && (cyc % 2 == 0);
        default: de = (sent < FRAME_LEN) && ($urandom_range(0, 2) != 0);
      endcase
      bus.in_de = de;
      if (de) begin
        bus.in_data = exp_q[sent];
        if (first_de < 0) first_de = cyc;
        sent++;
      end else begin
        bus.in_data = DW'($urandom);
      end
      proc_done = spurious && (cyc == 3);
      if (en_drop && sent > 1) en = 1'b0;
      tick();
      cyc++;
      if (bus.frm_href) begin
        obs_q.push_back(bus.frm_data);
        if (first_href < 0) first_href = cyc;
        last_href = cyc;
        if (!bus.frm_vsync) vs_err = 1'b1;
      end else if (obs_q.size() > 0 && bus.frm_data !== obs_q[obs_q.size() - 1]) begin
        hold_err = 1'b1;
      end
      if (first_href >= 0 && !bus.frm_vsync) fall = cyc;
    end
    bus.in_de = 1'b0;
    proc_done = 1'b0;
    en = 1'b1;

    n_checks++;
    if (fall < 0) begin
      n_fail++;
      $display("FAIL frame_end: vsync never fell within budget, got cycles=%0d required <200", cyc);
    end
    n_checks++;
    if (obs_q.size() !== FRAME_LEN) begin
      n_fail++;
      $display("FAIL href_count: got %0d required %0d", obs_q.size(), FRAME_LEN);
    end
    for (int i = 0; i < FRAME_LEN && i < obs_q.size(); i++)
      if (bad_idx < 0 && obs_q[i] !== exp_q[i]) bad_idx = i;
    n_checks++;
    if (bad_idx >= 0) begin
      n_fail++;
      $display("FAIL frame_data[%0d]: got %h required %h", bad_idx, obs_q[bad_idx], exp_q[bad_idx]);
    end
    n_checks++;
    if (first_href !== first_de + 1) begin
      n_fail++;
      $display("FAIL latency: first href cycle %0d required %0d", first_href, first_de + 1);
    end
    n_checks++;
    if (fall - last_href !== GAP_CYC + 1) begin
      n_fail++;
      $display("FAIL vsync_tail: vsync low %0d cycles after last href, required %0d", fall - last_href, GAP_CYC + 1);
    end
    n_checks++;
    if (vs_err || hold_err) begin
      n_fail++;
      $display("FAIL envelope: href_outside_vsync=%0d data_not_held=%0d required 0 0", vs_err, hold_err);
    end
    n_checks++;
    if ({busy, frame_cnt, drop_cnt} !== {1'b1, CW'(exp_frame), CW'(exp_drop)}) begin
      n_fail++;
      $display("FAIL wait_state: busy=%0d frame_cnt=%0d drop_cnt=%0d required 1 %0d %0d",
               busy, frame_cnt, drop_cnt, exp_frame, exp_drop);
    end
  endtask

  // proc_done in WAIT_DONE, optionally with a sample that must be dropped.
  task automatic finish_frame(input bit with_sample);
    proc_done   = 1'b1;
    bus.in_de   = with_sample;
    bus.in_data = DW'($urandom);
    tick();
    proc_done = 1'b0;
    bus.in_de = 1'b0;
    exp_frame++;
    if (with_sample) exp_drop++;
    n_checks++;
    if ({busy, bus.frm_href, frame_cnt, drop_cnt} !== {1'b0, 1'b0, CW'(exp_frame), CW'(exp_drop)}) begin
      n_fail++;
      $display("FAIL proc_done: busy=%0d href=%0d frame_cnt=%0d drop_cnt=%0d required 0 0 %0d %0d",
               busy, bus.frm_href, frame_cnt, drop_cnt, exp_frame, exp_drop);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    bus.in_de = 1'b1;
    bus.in_data = 16'hA5A5;
    repeat (3) tick();
    n_checks++;
    if ({bus.frm_vsync, bus.frm_href, bus.frm_data, busy, frame_cnt, drop_cnt, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset: vsync=%0d href=%0d data=%h busy=%0d frame=%0d drop=%0d tout=%0d required all 0",
               bus.frm_vsync, bus.frm_href, bus.frm_data, busy, frame_cnt, drop_cnt, timeout_err);
    end
    bus.in_de = 1'b0;
    rst_n = 1'b1;
    exp_frame = 0;
    exp_drop = 0;
    tick();
  endtask

  task automatic test_nominal();
    run_frame(0, 1'b1, 1'b0, 1'b0);
    finish_frame(1'b0);
  endtask

  task automatic test_busy_drop();
    bit href_seen = 0;
    run_frame(2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_de = 1'b1;
      bus.in_data = DW'($urandom);
      tick();
      exp_drop++;
      bus.in_de = 1'b0;
      if (bus.frm_href) href_seen = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
    end
    n_checks++;
    if ({drop_cnt, busy, href_seen} !== {CW'(exp_drop), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL busy_drop: drop_cnt=%0d busy=%0d href_seen=%0d required %0d 1 0",
               drop_cnt, busy, href_seen, exp_drop);
    end
    finish_frame(1'b0);
  endtask

  task automatic test_spurious_and_simultaneous();
    run_frame(2, 1'b0, 1'b1, 1'b1);
    finish_frame(1'b1);
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_simul: busy=%0d required 0", busy);
    end
  endtask

  task automatic test_gapped();
    run_frame(1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef SEQ_TIMEOUT_EN
    int k = 0;
    while (!timeout_err && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if ({k, busy, frame_cnt} !== {32'(TIMEOUT), 1'b0, CW'(exp_frame)}) begin
      n_fail++;
      $display("FAIL timeout: cycles=%0d busy=%0d frame_cnt=%0d required %0d 0 %0d",
               k, busy, frame_cnt, TIMEOUT, exp_frame);
    end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    tick();
    n_checks++;
    if ({timeout_err, frame_cnt} !== {1'b1, CW'(exp_frame)}) begin
      n_fail++;
      $display("FAIL timeout_sticky: timeout_err=%0d frame_cnt=%0d required 1 %0d",
               timeout_err, frame_cnt, exp_frame);
    end
`else
    repeat (1000) tick();
    n_checks++;
    if ({busy, timeout_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL no_timeout: busy=%0d timeout_err=%0d required 1 0", busy, timeout_err);
    end
    finish_frame(1'b0);
`endif
  endtask

  task automatic test_en_low();
    bit bad = 0;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_de = 1'b1;
      bus.in_data = DW'($urandom);
      proc_done = (i == 2);
      tick();
      if (busy || bus.frm_href || bus.frm_vsync) bad = 1'b1;
    end
    bus.in_de = 1'b0;
    proc_done = 1'b0;
    en = 1'b1;
    n_checks++;
    if ({bad, drop_cnt, frame_cnt} !== {1'b0, CW'(exp_drop), CW'(exp_frame)}) begin
      n_fail++;
      $display("FAIL en_low: activity=%0d drop_cnt=%0d frame_cnt=%0d required 0 %0d %0d",
               bad, drop_cnt, frame_cnt, exp_drop, exp_frame);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit bad = 0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_de = 1'b1;
      bus.in_data = DW'($urandom);
      tick();
      if (!bus.frm_href || !busy) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL pre_reset_stream: href/busy dropped, got bad=%0d required 0", bad);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({bus.frm_vsync, bus.frm_href, bus.frm_data, busy, frame_cnt, drop_cnt, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: vsync=%0d href=%0d data=%h busy=%0d frame=%0d drop=%0d tout=%0d required all 0",
               bus.frm_vsync, bus.frm_href, bus.frm_data, busy, frame_cnt, drop_cnt, timeout_err);
    end
    bus.in_de = 1'b0;
    rst_n = 1'b1;
    exp_frame = 0;
    exp_drop = 0;
    tick();
    run_frame(0, 1'b1, 1'b0, 1'b0);
    finish_frame(1'b0);
  endtask

  initial begin
    bus.in_de = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_nominal();
    test_busy_drop();
    test_spurious_and_simultaneous();
    test_gapped();
    test_timeout();
    test_en_low();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pitch_frame_sequencer.md
Name: pitch_frame_sequencer

Overview:
- Frames the continuous 16-bit audio sample stream into vsync/href-bracketed frames of FRAME_LEN samples for the resample → cache → WSOLA → Yout pipeline.
- After each frame it waits for that pipeline's completion pulse (Yout_finish) before opening the next frame.
- Samples arriving while the pipeline is busy are dropped and counted.
- Sits at the front of the pitch-shifter top in the clk_in1 (50 MHz, audio bclk) domain.

Parameters:
- FRAME_LEN, 500, samples per frame (≥2).
- GAP_CYC, 2, cycles vsync stays high after the last href of a frame (≥1).
- TIMEOUT, 4096, max WAIT_DONE cycles before abandoning the wait.
- DW, 16, sample width.
- CW, 16, width of the statistics counters.

Ports:
- clk_in1  in  1  system clock.
- rst_n  in  1  reset.
- en  in  1  enables starting new frames.
- in_de  in  1  input sample valid.
- in_data  in  DW  input sample.
- proc_done  in  1  one-cycle completion pulse from downstream (Yout_finish, already synchronised to clk_in1).
- frm_vsync  out  1  frame envelope to resampler.
- frm_href  out  1  frame sample valid.
- frm_data  out  DW  frame sample.
- busy  out  1  high whenever state ≠ IDLE.
- frame_cnt  out  CW  completed frames, wraps.
- drop_cnt  out  CW  dropped samples, saturates at all-ones.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clk_in1. While rst_n=0, every output, counter and state is 0 and state = IDLE. Reset asserted mid-frame aborts the frame immediately; no tail is emitted.
- All outputs are registered. Latency from in_de/in_data to frm_href/frm_data is 1 cycle.
- States: IDLE, STREAM, TAIL, WAIT_DONE.
- IDLE:
  - On en=1 and in_de=1: accept the sample, set sample count to 1, go to STREAM.
  - Next cycle, frm_vsync and frm_href both rise together with that sample.
  - in_de with en=0: sample ignored; drop_cnt does not count it.
- STREAM:
  - Each in_de sample is forwarded and sample count increments.
  - Gaps in in_de produce frm_href=0 with frm_vsync held high.
  - The sample making count == FRAME_LEN is forwarded, then go to TAIL with gap counter = 0.
  - Deasserting en mid-frame does not abort; the frame completes.
- TAIL:
  - frm_vsync is held high for GAP_CYC cycles after the last frm_href, then falls.
  - State then moves to WAIT_DONE and the wait counter clears.
  - in_de in TAIL: sample dropped.
- WAIT_DONE:
  - Every in_de increments drop_cnt (saturating).
  - proc_done=1: frame_cnt+1 (wraps), go to IDLE.
  - A sample present in the same cycle as proc_done is dropped; the next frame starts on the following in_de.
- proc_done outside WAIT_DONE is ignored; no counter changes.
- Count width: ceil(log2(FRAME_LEN+1)) bits. Wait counter: ceil(log2(TIMEOUT+1)) bits.
- frm_data holds its last value when frm_href=0.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - The WAIT_DONE counter increments each cycle.
  - On reaching TIMEOUT without proc_done: set timeout_err (cleared only by reset), go to IDLE, frame_cnt unchanged.
  - proc_done and timeout in the same cycle: proc_done wins.
- SEQ_TIMEOUT_EN undefined:
  - No wait counter is built; WAIT_DONE waits indefinitely.
  - timeout_err is tied to 0.

Decomposition:
- Package pitch_seq_pkg holds:
  - the state enum seq_state_t (IDLE=0, STREAM=1, TAIL=2, WAIT_DONE=3);
  - default constants FRAME_LEN_DEF=500, GAP_CYC_DEF=2, TIMEOUT_DEF=4096;
  - a clog2-based width function.
- One sub-module, seq_sat_cnt: a parameterised width counter with inc/clr and a saturate-or-wrap select. It is instantiated twice: drop_cnt saturating, frame_cnt wrapping.

Test Plan:
- Nominal frame (FRAME_LEN=8, GAP_CYC=2): 8 back-to-back samples 0x0001..0x0008.
  - Required: frm_href high exactly 8 cycles, 1 cycle after in_de.
  - Required: frm_vsync rises with the first href and falls 2 cycles after the last.
  - Required: busy=1; proc_done then gives frame_cnt=1.
- Gapped input: 8 samples with in_de toggling every other cycle → 8 frm_href pulses, vsync continuous, data order preserved.
- Busy drop: 5 samples during WAIT_DONE, then proc_done → drop_cnt=5; the next sample starts frame 2 with frame_cnt=1 before its completion.
- Spurious/simultaneous: proc_done during STREAM → ignored. proc_done coinciding with in_de in WAIT_DONE → IDLE, drop_cnt+1, the next in_de opens a frame.
- Timeout (SEQ_TIMEOUT_EN, TIMEOUT=64): no proc_done → timeout_err=1 64 cycles after entering WAIT_DONE, state IDLE, frame_cnt=0. Without the macro: still WAIT_DONE after 1000 cycles, timeout_err=0.
- Reset mid-STREAM after 3 samples → all outputs 0 the next cycle; a fresh 8-sample frame afterwards behaves as nominal.
